// File: rtl/noc_pkg.sv
// Shared types and constants for the 5-port NoC router.
//   PORTS / PORT_W : router port count and port-index width
//   port_idx_t     : port index type
//   port_e         : symbolic port names (LOCAL, NORTH, EAST, SOUTH, WEST)
//   alloc_state_t  : per-output allocator state (IDLE, LOCKED)
//   next_port()    : round-robin successor of a port index, with wrap
package noc_pkg;

  localparam int unsigned PORTS  = 5;
  localparam int unsigned PORT_W = $clog2(PORTS);

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef enum logic [PORT_W-1:0] {
    LOCAL,
    NORTH,
    EAST,
    SOUTH,
    WEST
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  function automatic port_idx_t next_port(input port_idx_t p);
    if (p == port_idx_t'(PORTS - 1)) begin
      return '0;
    end
    return p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter, one per router output.
//   i_req   : request vector, one bit per input port
//   i_ptr   : highest-priority input; search runs upward from here with wrap
//   o_grant : one-hot grant (all zero when nothing requests)
//   o_idx   : index of the granted input (0 when nothing requests)
//   o_valid : some input was granted
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  logic [PORTS-1:0] i_req,
  input  port_idx_t        i_ptr,
  output logic [PORTS-1:0] o_grant,
  output port_idx_t        o_idx,
  output logic             o_valid
);

  always_comb begin
    port_idx_t w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      w_pos = port_idx_t'((32'(i_ptr) + k) % PORTS);
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Switch allocator for the 5-port wormhole router. Each output arbitrates
// round-robin among head-of-line flits addressed to it, locks to the winning
// input until its tail flit transfers, and drives crossbar selects and input
// pop strobes combinationally so a granted flit moves in the same cycle.
//   clk, rst     : clock; asynchronous active-high reset
//   req_valid    : input i has a head-of-line flit
//   req_dest     : destination output of input i's flit
//   req_tail     : input i's flit is a tail (head+tail = single-flit packet)
//   out_ready    : downstream of output o accepts a flit
//   out_valid    : output o carries a flit
//   out_sel      : crossbar select, input index driving output o
//   in_ready     : input i's flit transfers this cycle (pop strobe)
//   out_locked   : output o is locked to a packet
//   err_bad_dest : registered pulse, a valid request named a nonexistent output
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             req_valid,
  input  logic [PORTS-1:0][PORT_W-1:0] req_dest,
  input  logic [PORTS-1:0]             req_tail,
  input  logic [PORTS-1:0]             out_ready,
  output logic [PORTS-1:0]             out_valid,
  output logic [PORTS-1:0][PORT_W-1:0] out_sel,
  output logic [PORTS-1:0]             in_ready,
  output logic [PORTS-1:0]             out_locked,
  output logic                         err_bad_dest
);

  localparam logic [PORT_W:0] PortLimit = (PORT_W + 1)'(PORTS);

  logic [PORTS-1:0]             w_lock;
  logic [PORTS-1:0][PORT_W-1:0] w_owner;
  logic [PORTS-1:0]             w_owned;
  logic [PORTS-1:0][PORTS-1:0]  w_pop;    // [output][input]
  logic [PORTS-1:0]             w_bad;
  logic                         r_err_bad_dest;

  // An input holding a locked output must not compete for any other output.
  always_comb begin
    w_owned = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      if (w_lock[o]) begin
        w_owned[w_owner[o]] = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      in_ready = in_ready | w_pop[o];
    end
  end

  always_comb begin
    w_bad = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_bad[i] = req_valid[i] && ({1'b0, req_dest[i]} >= PortLimit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_bad_dest <= 1'b0;
    end else begin
      r_err_bad_dest <= |w_bad;
    end
  end

  assign err_bad_dest = r_err_bad_dest;

  for (genvar o = 0; o < PORTS; o++) begin : g_out
    alloc_state_t     r_state, w_state_d;
    port_idx_t        r_owner, w_owner_d;
    port_idx_t        r_ptr, w_ptr_d;
    port_idx_t        r_sel, w_sel;
    logic [PORTS-1:0] w_cand, w_grant, w_mask, w_pop_o;
    port_idx_t        w_arb_idx;
    logic             w_arb_valid, w_valid, w_xfer;

    // Out-of-range destinations never match any o, so they are never granted.
    always_comb begin
      w_cand = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
        w_cand[i] = req_valid[i] && (req_dest[i] == port_idx_t'(o)) && !w_owned[i];
      end
    end

    noc_rr_arbiter u_arb (
      .i_req   (w_cand),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
    );

    always_comb begin
      w_state_d = r_state;
      w_owner_d = r_owner;
      w_ptr_d   = r_ptr;
      w_valid   = 1'b0;
      w_sel     = r_sel;
      w_mask    = '0;

      unique case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            w_valid = 1'b1;
            w_sel   = w_arb_idx;
            w_mask  = w_grant;
          end
        end
        LOCKED: begin
          w_valid         = req_valid[r_owner];
          w_sel           = r_owner;
          w_mask[r_owner] = 1'b1;
        end
      endcase

      if (rst) begin
        w_valid = 1'b0;
        w_sel   = r_sel;
      end

      w_xfer  = w_valid && out_ready[o];
      w_pop_o = w_xfer ? w_mask : '0;

      if (w_xfer) begin
        unique case (r_state)
          IDLE: begin
            w_ptr_d = next_port(w_sel);
            if (!req_tail[w_sel]) begin
              w_state_d = LOCKED;
              w_owner_d = w_sel;
            end
          end
          LOCKED: begin
            if (req_tail[r_owner]) begin
              w_state_d = IDLE;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_owner <= '0;
        r_ptr   <= '0;
        r_sel   <= '0;
      end else begin
        r_state <= w_state_d;
        r_owner <= w_owner_d;
        r_ptr   <= w_ptr_d;
        r_sel   <= w_sel;
      end
    end

    assign out_valid[o]  = w_valid;
    assign out_sel[o]    = w_sel;
    assign out_locked[o] = (r_state == LOCKED) && !rst;
    assign w_lock[o]     = (r_state == LOCKED);
    assign w_owner[o]    = r_owner;
    assign w_pop[o]      = w_pop_o;
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
module tb_noc_switch_allocator;
  import noc_pkg::*;

  typedef struct {
    string       name;
    logic        rst;
    logic [4:0]  rv;
    logic [14:0] rd;
    logic [4:0]  rt;
    logic [4:0]  ordy;
    logic [4:0]  ov;
    logic [14:0] os;
    logic [4:0]  sm;   // lanes of out_sel to check
    logic [4:0]  ir;
    logic [4:0]  ol;
    logic        err;
  } vec_t;

  logic                         clk;
  logic                         rst;
  logic [PORTS-1:0]             req_valid;
  logic [PORTS-1:0][PORT_W-1:0] req_dest;
  logic [PORTS-1:0]             req_tail;
  logic [PORTS-1:0]             out_ready;
  logic [PORTS-1:0]             out_valid;
  logic [PORTS-1:0][PORT_W-1:0] out_sel;
  logic [PORTS-1:0]             in_ready;
  logic [PORTS-1:0]             out_locked;
  logic                         err_bad_dest;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t e;
  logic [14:0] m;
  int total = 0;
  int bad   = 0;

  noc_switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_dest     (req_dest),
    .req_tail     (req_tail),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_sel      (out_sel),
    .in_ready     (in_ready),
    .out_locked   (out_locked),
    .err_bad_dest (err_bad_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] dst(input int a0, input int a1, input int a2,
                                      input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic add(input string nm, input logic r, input logic [4:0] rv,
                     input logic [14:0] rd, input logic [4:0] rt, input logic [4:0] ordy,
                     input logic [4:0] ov, input logic [14:0] os, input logic [4:0] sm,
                     input logic [4:0] ir, input logic [4:0] ol, input logic er);
    vec_t v;
    v.name = nm; v.rst = r; v.rv = rv; v.rd = rd; v.rt = rt; v.ordy = ordy;
    v.ov = ov; v.os = os; v.sm = sm; v.ir = ir; v.ol = ol; v.err = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string vn, input string f, input logic [14:0] act,
                     input logic [14:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s %s: got %h want %h", vn, f, act, req);
    end
  endtask

  // Scoreboard: each expected record is popped mid-cycle, after inputs settle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int j = 0; j < 5; j++) m[3*j +: 3] = {3{e.sm[j]}};
      chk(e.name, "out_valid", 15'(out_valid), 15'(e.ov));
      chk(e.name, "out_sel", out_sel & m, e.os & m);
      chk(e.name, "in_ready", 15'(in_ready), 15'(e.ir));
      chk(e.name, "out_locked", 15'(out_locked), 15'(e.ol));
      chk(e.name, "err_bad_dest", 15'(err_bad_dest), 15'(e.err));
    end
  end

  localparam logic [4:0] A = 5'b11111;

  initial begin
    rst = 1'b1; req_valid = '0; req_dest = '0; req_tail = '0; out_ready = '0;

    // Reset forces outputs low even with live requests.
    add("rst_hold", 1, A, dst(0,0,0,0,0), A, A, 0, 0, A, 0, 0, 0);
    add("rst_idle", 0, 0, dst(0,0,0,0,0), 0, A, 0, 0, A, 0, 0, 0);
    // Single flit 1->0, then ptr[0] checks (2, wrap to 0, then 1).
    add("sf_1to0",   0, 5'b00010, dst(0,0,0,0,0), A, A, 5'b00001, dst(1,0,0,0,0), 5'b00001, 5'b00010, 0, 0);
    add("ptr0_2",    0, 5'b00111, dst(0,0,0,0,0), A, A, 5'b00001, dst(2,0,0,0,0), 5'b00001, 5'b00100, 0, 0);
    add("ptr0_wrap", 0, 5'b00011, dst(0,0,0,0,0), A, A, 5'b00001, dst(0,0,0,0,0), 5'b00001, 5'b00001, 0, 0);
    add("ptr0_1",    0, 5'b00011, dst(0,0,0,0,0), A, A, 5'b00001, dst(1,0,0,0,0), 5'b00001, 5'b00010, 0, 0);
    // All five inputs to output 1: order 0,1,2,3,4,0.
    for (int k = 0; k < 6; k++) begin
      add($sformatf("rr_out1_%0d", k), 0, A, dst(1,1,1,1,1), A, A, 5'b00010,
          dst(0, k % 5, 0, 0, 0), 5'b00010, 5'(1) << (k % 5), 0, 0);
    end
    // 3-flit packet 2->4 with input 3 waiting on output 4.
    add("pkt_head", 0, 5'b01100, dst(0,0,4,4,0), 5'b01000, A, 5'b10000, dst(0,0,0,0,2), 5'b10000, 5'b00100, 5'b00000, 0);
    add("pkt_body", 0, 5'b01100, dst(0,0,4,4,0), 5'b01000, A, 5'b10000, dst(0,0,0,0,2), 5'b10000, 5'b00100, 5'b10000, 0);
    add("pkt_tail", 0, 5'b01100, dst(0,0,4,4,0), 5'b01100, A, 5'b10000, dst(0,0,0,0,2), 5'b10000, 5'b00100, 5'b10000, 0);
    add("pkt_next", 0, 5'b01000, dst(0,0,4,4,0), 5'b01000, A, 5'b10000, dst(0,0,0,0,3), 5'b10000, 5'b01000, 5'b00000, 0);
    // Back-pressure on output 2 mid-packet from input 0; owner's dest is ignored.
    add("bp_head",   0, 5'b00001, dst(2,0,0,0,0), 0, A, 5'b00100, dst(0,0,0,0,0), 5'b00100, 5'b00001, 5'b00000, 0);
    add("bp_stall0", 0, 5'b00001, dst(2,0,0,0,0), 0, 5'b11011, 5'b00100, dst(0,0,0,0,0), 5'b00100, 0, 5'b00100, 0);
    add("bp_stall1", 0, 5'b00001, dst(3,0,0,0,0), 0, 5'b11011, 5'b00100, dst(0,0,0,0,0), 5'b00100, 0, 5'b00100, 0);
    add("bp_stall2", 0, 5'b00001, dst(2,0,0,0,0), 0, 5'b11011, 5'b00100, dst(0,0,0,0,0), 5'b00100, 0, 5'b00100, 0);
    add("bp_stall3", 0, 5'b00001, dst(2,0,0,0,0), 0, 5'b11011, 5'b00100, dst(0,0,0,0,0), 5'b00100, 0, 5'b00100, 0);
    add("bp_resume", 0, 5'b00001, dst(2,0,0,0,0), 0, A, 5'b00100, dst(0,0,0,0,0), 5'b00100, 5'b00001, 5'b00100, 0);
    add("bp_tail",   0, 5'b00001, dst(2,0,0,0,0), 5'b00001, A, 5'b00100, dst(0,0,0,0,0), 5'b00100, 5'b00001, 5'b00100, 0);
    // Parallel 0->3, 1->4, 2->0.
    add("par_head",    0, 5'b00111, dst(3,4,0,0,0), 0, A, 5'b11001, dst(2,0,0,0,1), 5'b11001, 5'b00111, 5'b00000, 0);
    add("par_tail",    0, 5'b00111, dst(3,4,0,0,0), 5'b00111, A, 5'b11001, dst(2,0,0,0,1), 5'b11001, 5'b00111, 5'b11001, 0);
    add("par_partial", 0, 5'b00111, dst(3,4,0,0,0), 5'b00111, 5'b01111, 5'b11001, dst(2,0,0,0,1), 5'b11001, 5'b00101, 0, 0);
    // Bad destination on input 4, then out_sel[1] holds when idle.
    add("bad_dest",  0, 5'b11000, dst(0,0,0,1,6), A, A, 5'b00010, dst(0,3,0,0,0), 5'b00010, 5'b01000, 0, 0);
    add("bad_pulse", 0, 0, dst(0,0,0,0,0), 0, A, 0, dst(0,3,0,0,0), 5'b00010, 0, 0, 1);
    add("bad_clear", 0, 0, dst(0,0,0,0,0), 0, A, 0, dst(0,3,0,0,0), 5'b00010, 0, 0, 0);
    // Reset mid-packet on output 2.
    add("rp_head",    0, 5'b00010, dst(0,2,0,0,0), 0, A, 5'b00100, dst(0,0,1,0,0), 5'b00100, 5'b00010, 5'b00000, 0);
    add("rp_body",    0, 5'b00010, dst(0,2,0,0,0), 0, A, 5'b00100, dst(0,0,1,0,0), 5'b00100, 5'b00010, 5'b00100, 0);
    add("rp_rst",     1, 5'b00010, dst(0,2,0,0,0), 0, A, 0, dst(0,0,0,0,0), A, 0, 0, 0);
    add("rp_release", 0, 5'b00010, dst(0,2,0,0,0), 0, A, 5'b00100, dst(0,0,1,0,0), 5'b00100, 5'b00010, 5'b00000, 0);
    add("rp_tail",    0, 5'b00010, dst(0,2,0,0,0), 5'b00010, A, 5'b00100, dst(0,0,1,0,0), 5'b00100, 5'b00010, 5'b00100, 0);
    add("rp_done",    0, 0, dst(0,0,0,0,0), 0, A, 0, dst(0,0,1,0,0), 5'b00100, 0, 0, 0);
    // U-turn 3->3.
    add("uturn", 0, 5'b01000, dst(0,0,0,3,0), 5'b01000, A, 5'b01000, dst(0,0,0,3,0), 5'b01000, 5'b01000, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(posedge clk);
      #1;
      rst       = vecs[n].rst;
      req_valid = vecs[n].rv;
      req_dest  = vecs[n].rd;
      req_tail  = vecs[n].rt;
      out_ready = vecs[n].ordy;
      exp_q.push_back(vecs[n]);
    end

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
